pipelined_ripple_adder: RTL and testbench
=========================================

Name: pipelined_ripple_adder

Overview:
- Parametrised, pipelined successor to the 16-bit combinational ripple-carry adder.
- Splits a WIDTH-bit ripple add/subtract into STAGES equal slices, with a registered carry between slices, so the clock period is bounded by one slice's ripple.
- Uses a valid/ready stream interface on both sides and adds a subtract mode plus a signed-overflow flag.
- Sits in the datapath wherever a wide adder must meet timing: the ALU, address generation, and DFT scan-chain test targets.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be ≥ 1.
- STAGES, 4, number of pipeline stages, which is also the slice count. Must be ≥ 1 and divide WIDTH; violating either is an elaboration-time error.
- SLICE, WIDTH/STAGES, derived bit width of each slice. Not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block accepts a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in, used only when sub=0
- sub  input  1  1 = a − b, 0 = a + b + cin
- out_valid  output  1  result beat present
- out_ready  input  1  downstream accepts the result
- sum  output  WIDTH  result, modulo 2^WIDTH
- co  output  1  carry-out of the MSB; for subtract, 1 means no borrow
- ovf  output  1  two's-complement signed overflow

Behaviour:
- Operand preparation at accept: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Slice k (0 = LSBs) computes bits [k*SLICE +: SLICE] in stage k, using the registered carry from stage k−1 (stage 0 uses c0).
- Skew: operand bits for slice k are delayed k cycles before use.
- Deskew: the result of slice k is delayed STAGES−1−k cycles, so all sum bits of one beat emerge together.
- Each stage carries a valid bit. out_valid is the last stage's valid bit.
- Global advance: adv = ~out_valid | out_ready.
  - in_ready = adv.
  - A beat is accepted when in_valid & in_ready.
  - When adv=1, all stages shift one position and the stage-0 valid bit loads in_valid.
  - When adv=0, every register holds its value.
- Latency: a beat accepted in cycle t has out_valid=1 in cycle t+STAGES, provided there is no stall. Throughput is one beat per cycle.
- Bubbles: invalid stages still shift. Bubbles are not collapsed; this is the accepted simple-stall scheme.
- Outputs hold stable while out_valid=1 & out_ready=0 (AXI-style rule). in_valid may drop or change without effect while in_ready=0.
- Flag generation:
  - co = carry out of bit WIDTH−1.
  - ovf = carry into bit WIDTH−1 XOR co.
  - Both are registered alongside sum in the same beat.
- STAGES=1: a single registered full-width add with latency 1. in_ready/out_ready semantics are unchanged.
- Reset (rst_n=0, asynchronous):
  - All valid bits, data registers and carry registers clear immediately.
  - out_valid=0, sum=0, co=0, ovf=0.
  - in_ready=1, since out_valid=0.
  - In-flight beats are discarded, not completed.
- Reset release: the first accept is possible on the first clock edge with rst_n=1.
- Simultaneous accept and emit under adv=1 is legal and loses no beat.
- Wrap-around: sum wraps modulo 2^WIDTH; only co and ovf report it.
- Ordering: results are in strict acceptance order, with no duplication or loss.

Test Plan:
1. WIDTH=16, STAGES=4; a=0x0000, b=0xFFFF, cin=0, sub=0, out_ready=1 -> out_valid exactly 4 cycles after accept; sum=0xFFFF, co=0, ovf=0.
2. a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, co=1, ovf=0. The carry crosses all 4 registered slice boundaries.
3. sub=1: a=0x8000, b=0x0001 -> sum=0x7FFF, co=1, ovf=1. Then a=0x0000, b=0x0001 -> sum=0xFFFF, co=0, ovf=0.
4. Stream 8 back-to-back random beats with out_ready=1 -> 8 consecutive out_valid cycles, each matching a reference model, in order. in_ready stays 1 throughout.
5. Fill the pipeline, then hold out_ready=0 for 5 cycles -> in_ready=0, and sum/co/ovf/out_valid are stable. After release, remaining beats drain in order, with no loss or duplicate.
6. Pulse rst_n low with 3 beats in flight, asynchronously mid-cycle -> out_valid=0 and sum=0 before the next edge, and no stale beat appears afterwards. Re-run scenario 4 with STAGES=1 and STAGES=16 -> latency 1 and 16 respectively.

Source files
------------

// File: rtl/pipelined_ripple_adder.sv
// Ripple-carry add/subtract split into STAGES equal slices with a registered carry between
// slices. Operands are skewed in, results are deskewed out, and a global stall gates every stage.
module pipelined_ripple_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int unsigned SLICE = (STAGES == 0) ? 1 : WIDTH / STAGES;

  if (WIDTH == 0 || STAGES == 0 || (STAGES != 0 && (WIDTH % STAGES) != 0)) begin : g_param_check
    $error("pipelined_ripple_adder: WIDTH must be >= 1 and a multiple of STAGES >= 1");
  end

  logic                           adv;
  logic [STAGES-1:0]              vld_q, vld_d;
  logic [STAGES-1:0][WIDTH-1:0]   acc_q, acc_d;
  logic [STAGES-1:0][WIDTH-1:0]   bop_q;
  logic [STAGES-1:0]              cy_q, cy_d;
  logic                           ovf_q, ovf_d;

  // Per-stage inputs: stage 0 takes the prepared operands, stage k takes stage k-1 registers.
  logic [STAGES-1:0][WIDTH-1:0]   src_a, src_b;
  logic [STAGES-1:0]              src_c;
  logic [STAGES-1:0][SLICE:0]     slice_add;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  always_comb begin
    src_a    = '0;
    src_b    = '0;
    src_c    = '0;
    vld_d    = '0;
    src_a[0] = a;
    src_b[0] = sub ? ~b : b;
    src_c[0] = sub ? 1'b1 : cin;
    vld_d[0] = in_valid;
    for (int unsigned s = 1; s < STAGES; s++) begin
      src_a[s] = acc_q[s-1];
      src_b[s] = bop_q[s-1];
      src_c[s] = cy_q[s-1];
      vld_d[s] = vld_q[s-1];
    end
  end

  // acc carries finished sum bits below the current slice and still-pending A bits above it.
  always_comb begin
    acc_d     = src_a;
    cy_d      = '0;
    slice_add = '0;
    for (int unsigned s = 0; s < STAGES; s++) begin
      slice_add[s] = {1'b0, src_a[s][s*SLICE +: SLICE]}
                   + {1'b0, src_b[s][s*SLICE +: SLICE]}
                   + {{SLICE{1'b0}}, src_c[s]};
      acc_d[s][s*SLICE +: SLICE] = slice_add[s][SLICE-1:0];
      cy_d[s] = slice_add[s][SLICE];
    end
    // Carry into the MSB recovered as sum ^ a ^ b at that bit.
    ovf_d = slice_add[STAGES-1][SLICE-1] ^ src_a[STAGES-1][WIDTH-1]
          ^ src_b[STAGES-1][WIDTH-1] ^ cy_d[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      acc_q <= '0;
      bop_q <= '0;
      cy_q  <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      vld_q <= vld_d;
      acc_q <= acc_d;
      bop_q <= src_b;
      cy_q  <= cy_d;
      ovf_q <= ovf_d;
    end
  end

  // The last stage's copy of B has no consumer.
  logic unused_bop;
  assign unused_bop = ^bop_q[STAGES-1];

  assign out_valid = vld_q[STAGES-1];
  assign sum       = acc_q[STAGES-1];
  assign co        = cy_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Scoreboard bench for pipelined_ripple_adder: STAGES=4 main instance plus STAGES=1 and
// STAGES=16 instances exercised for latency.
module tb_pipelined_ripple_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_valid_x = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;

  logic         in_ready, out_valid, co, ovf;
  logic [W-1:0] sum;
  logic         in_ready1, out_valid1, co1, ovf1;
  logic [W-1:0] sum1;
  logic         in_ready16, out_valid16, co16, ovf16;
  logic [W-1:0] sum16;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;
    int           cyc;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];
  exp_t q16[$];

  pipelined_ripple_adder #(.WIDTH(W), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .co(co),
    .ovf(ovf)
  );

  pipelined_ripple_adder #(.WIDTH(W), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_x), .in_ready(in_ready1), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid1), .out_ready(1'b1), .sum(sum1), .co(co1),
    .ovf(ovf1)
  );

  pipelined_ripple_adder #(.WIDTH(W), .STAGES(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_x), .in_ready(in_ready16), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid16), .out_ready(1'b1), .sum(sum16), .co(co16),
    .ovf(ovf16)
  );

  // Reference: full-width add, overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                                 input logic s, input int t);
    exp_t         m;
    logic [W-1:0] ye;
    logic         c0;
    logic [W:0]   r;
    ye    = s ? ~y : y;
    c0    = s ? 1'b1 : c;
    r     = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, c0};
    m.sum = r[W-1:0];
    m.co  = r[W];
    m.ovf = (x[W-1] == ye[W-1]) && (r[W-1] != x[W-1]);
    m.cyc = t;
    return m;
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, input logic s);
    in_valid = v;
    a        = x;
    b        = y;
    cin      = c;
    sub      = s;
  endtask

  // Sample on the falling edge and record beats the coming rising edge will accept.
  task automatic tick();
    @(negedge clk);
    if (in_valid && in_ready) q4.push_back(model(a, b, cin, sub, cyc));
    if (in_valid_x && in_ready1) q1.push_back(model(a, b, cin, sub, cyc));
    if (in_valid_x && in_ready16) q16.push_back(model(a, b, cin, sub, cyc));
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    out_ready = 1'b1;
    #2;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (sum !== '0) $display("FAIL reset sum: got %h want 0000", sum); else n_pass++;
    n_checks++; if (co !== 1'b0 || ovf !== 1'b0) $display("FAIL reset flags: got co=%b ovf=%b want 0 0", co, ovf); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset in_ready: got %b want 1", in_ready); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    next();
  endtask

  task automatic test_directed();
    logic [W-1:0] va[5] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h0000, 16'h7FFF};
    logic [W-1:0] vb[5] = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0001, 16'h0001};
    logic         vc[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic         vs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_t         e;
    bit           got;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, va[i], vb[i], vc[i], vs[i]);
      tick();
      next();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
        tick();
        if (out_valid) begin
          got = 1'b1;
          n_checks++;
          if (q4.size() == 0) $display("FAIL directed%0d unexpected beat: got sum %h want none", i, sum);
          else begin
            n_pass++;
            e = q4.pop_front();
            n_checks++; if (sum !== e.sum) $display("FAIL directed%0d sum: got %h want %h", i, sum, e.sum); else n_pass++;
            n_checks++; if (co !== e.co) $display("FAIL directed%0d co: got %b want %b", i, co, e.co); else n_pass++;
            n_checks++; if (ovf !== e.ovf) $display("FAIL directed%0d ovf: got %b want %b", i, ovf, e.ovf); else n_pass++;
            n_checks++; if (cyc - e.cyc !== 4) $display("FAIL directed%0d latency: got %0d want 4", i, cyc - e.cyc); else n_pass++;
          end
        end
        next();
      end
      n_checks++; if (!got) $display("FAIL directed%0d timeout: got no out_valid want 1", i); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    exp_t        e;
    int          n_out, first, last;
    n_out = 0; first = -1; last = -1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      r = $urandom();
      if (i < 8) drive(1'b1, r[15:0], 16'($urandom()), r[16], r[17]);
      else drive(1'b0, '0, '0, 1'b0, 1'b0);
      tick();
      if (i < 8) begin
        n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b in_ready cycle %0d: got %b want 1", i, in_ready); else n_pass++;
      end
      if (out_valid) begin
        if (first < 0) first = i;
        last = i;
        n_out++;
        n_checks++;
        if (q4.size() == 0) $display("FAIL b2b unexpected beat: got sum %h want none", sum);
        else begin
          n_pass++;
          e = q4.pop_front();
          n_checks++; if ({sum, co, ovf} !== {e.sum, e.co, e.ovf}) $display("FAIL b2b result: got %h/%b/%b want %h/%b/%b", sum, co, ovf, e.sum, e.co, e.ovf); else n_pass++;
          n_checks++; if (cyc - e.cyc !== 4) $display("FAIL b2b latency: got %0d want 4", cyc - e.cyc); else n_pass++;
        end
      end
      next();
    end
    n_checks++; if (n_out !== 8 || last - first !== 7) $display("FAIL b2b run: got %0d beats over %0d cycles want 8 over 8", n_out, last - first + 1); else n_pass++;
  endtask

  task automatic test_stall();
    logic [31:0] r;
    exp_t        e;
    int          n_out;
    n_out = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r = $urandom();
      drive(1'b1, r[15:0], 16'($urandom()), r[16], r[17]);
      tick();
      next();
    end
    for (int i = 0; i < 5; i++) begin
      r = $urandom();
      drive(r[0], r[31:16], r[15:0], r[1], r[2]);
      tick();
      n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) $display("FAIL stall%0d handshake: got in_ready=%b out_valid=%b want 0 1", i, in_ready, out_valid); else n_pass++;
      n_checks++;
      if (q4.size() == 0) $display("FAIL stall%0d scoreboard: got empty want 4 entries", i);
      else if ({sum, co, ovf} !== {q4[0].sum, q4[0].co, q4[0].ovf})
        $display("FAIL stall%0d hold: got %h/%b/%b want %h/%b/%b", i, sum, co, ovf, q4[0].sum, q4[0].co, q4[0].ovf);
      else n_pass++;
      next();
    end
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) begin
        n_out++;
        n_checks++;
        if (q4.size() == 0) $display("FAIL stall drain duplicate: got sum %h want none", sum);
        else begin
          n_pass++;
          e = q4.pop_front();
          n_checks++; if ({sum, co, ovf} !== {e.sum, e.co, e.ovf}) $display("FAIL stall drain: got %h/%b/%b want %h/%b/%b", sum, co, ovf, e.sum, e.co, e.ovf); else n_pass++;
        end
      end
      next();
    end
    n_checks++; if (n_out !== 4) $display("FAIL stall drain count: got %0d want 4", n_out); else n_pass++;
  endtask

  task automatic test_reset_inflight();
    int stale;
    stale = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h1234 + 16'(i), 16'h1111, 1'b1, 1'b0);
      tick();
      next();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    next();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL inflight pre-reset out_valid: got %b want 1", out_valid); else n_pass++;
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL inflight reset out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (sum !== '0 || co !== 1'b0 || ovf !== 1'b0) $display("FAIL inflight reset data: got %h/%b/%b want 0000/0/0", sum, co, ovf); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL inflight reset in_ready: got %b want 1", in_ready); else n_pass++;
    q4.delete();
    #2;
    rst_n = 1'b1;
    next();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) stale++;
      next();
    end
    n_checks++; if (stale !== 0) $display("FAIL inflight stale beats: got %0d want 0", stale); else n_pass++;
  endtask

  task automatic test_latency();
    logic [31:0] r;
    exp_t        e;
    out_ready = 1'b1;
    for (int i = 0; i < 28; i++) begin
      r = $urandom();
      if (i < 8) begin
        drive(1'b1, r[15:0], 16'($urandom()), r[16], r[17]);
        in_valid_x = 1'b1;
      end else begin
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        in_valid_x = 1'b0;
      end
      tick();
      if (out_valid1) begin
        n_checks++;
        if (q1.size() == 0) $display("FAIL lat1 unexpected beat: got sum %h want none", sum1);
        else begin
          n_pass++;
          e = q1.pop_front();
          n_checks++; if ({sum1, co1, ovf1} !== {e.sum, e.co, e.ovf}) $display("FAIL lat1 result: got %h/%b/%b want %h/%b/%b", sum1, co1, ovf1, e.sum, e.co, e.ovf); else n_pass++;
          n_checks++; if (cyc - e.cyc !== 1) $display("FAIL lat1 latency: got %0d want 1", cyc - e.cyc); else n_pass++;
        end
      end
      if (out_valid16) begin
        n_checks++;
        if (q16.size() == 0) $display("FAIL lat16 unexpected beat: got sum %h want none", sum16);
        else begin
          n_pass++;
          e = q16.pop_front();
          n_checks++; if ({sum16, co16, ovf16} !== {e.sum, e.co, e.ovf}) $display("FAIL lat16 result: got %h/%b/%b want %h/%b/%b", sum16, co16, ovf16, e.sum, e.co, e.ovf); else n_pass++;
          n_checks++; if (cyc - e.cyc !== 16) $display("FAIL lat16 latency: got %0d want 16", cyc - e.cyc); else n_pass++;
        end
      end
      if (out_valid) begin
        n_checks++;
        if (q4.size() == 0) $display("FAIL lat4 unexpected beat: got sum %h want none", sum);
        else begin
          n_pass++;
          e = q4.pop_front();
          n_checks++; if ({sum, co, ovf} !== {e.sum, e.co, e.ovf}) $display("FAIL lat4 result: got %h/%b/%b want %h/%b/%b", sum, co, ovf, e.sum, e.co, e.ovf); else n_pass++;
          n_checks++; if (cyc - e.cyc !== 4) $display("FAIL lat4 latency: got %0d want 4", cyc - e.cyc); else n_pass++;
        end
      end
      next();
    end
    n_checks++; if (q1.size() + q16.size() + q4.size() !== 0) $display("FAIL latency leftovers: got %0d/%0d/%0d want 0/0/0", q1.size(), q16.size(), q4.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_inflight();
    test_latency();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
